// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel divider, h/v position counters, active-area coordinates, syncs and strobes.
// Optional build macro VGA_SCAN_PREFETCH_EN delays hsync/vsync/video_on by one pixel period.
module vga_scan_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [8:0] row,
  output logic [9:0] col,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_C   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_C   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_C   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       advance_s;
  logic [9:0] h_cnt_r, v_cnt_r;
  logic [9:0] h_nxt_s, v_nxt_s;
  logic       vid_nxt_s, hs_nxt_s, vs_nxt_s;
  logic [8:0] row_r;
  logic [9:0] col_r;
  logic       video_on_r, hsync_r, vsync_r;
  logic       pix_tick_r, line_start_r, frame_start_r;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam logic [DIV_W-1:0] DIV_MAX_C  = DIV_W'(CLK_DIV - 1);
      localparam logic [DIV_W-1:0] DIV_ZERO_C = DIV_W'(0);
      localparam logic [DIV_W-1:0] DIV_ONE_C  = DIV_W'(1);
      logic [DIV_W-1:0] div_cnt_r;

      // Pixel-rate divider; the last count of each period is the advance edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          div_cnt_r <= DIV_ZERO_C;
        end else if (div_cnt_r == DIV_MAX_C) begin
          div_cnt_r <= DIV_ZERO_C;
        end else begin
          div_cnt_r <= div_cnt_r + DIV_ONE_C;
        end
      end

      assign advance_s = (div_cnt_r == DIV_MAX_C);
    end else begin : g_nodiv
      assign advance_s = 1'b1;
    end
  endgenerate

  // Next raster position, wrapping at line and frame ends.
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (h_cnt_r == H_LAST_C) begin
      h_nxt_s = 10'd0;
      if (v_cnt_r == V_LAST_C) begin
        v_nxt_s = 10'd0;
      end else begin
        v_nxt_s = v_cnt_r + 10'd1;
      end
    end else begin
      h_nxt_s = h_cnt_r + 10'd1;
    end
  end

  // Decode from the next position so registered outputs describe the pixel being scanned.
  always_comb begin
    vid_nxt_s = (h_nxt_s < H_ACT_C) && (v_nxt_s < V_ACT_C);
    hs_nxt_s  = !((h_nxt_s >= H_SS_C) && (h_nxt_s < H_SE_C));
    vs_nxt_s  = !((v_nxt_s >= V_SS_C) && (v_nxt_s < V_SE_C));
  end

  // Position and aligned outputs move on advance edges; strobes are re-evaluated every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_r       <= H_LAST_C;
      v_cnt_r       <= V_LAST_C;
      row_r         <= 9'd0;
      col_r         <= 10'd0;
      video_on_r    <= 1'b0;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      pix_tick_r    <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      pix_tick_r    <= advance_s;
      line_start_r  <= advance_s && (h_nxt_s == 10'd0);
      frame_start_r <= advance_s && (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
      if (advance_s) begin
        h_cnt_r    <= h_nxt_s;
        v_cnt_r    <= v_nxt_s;
        row_r      <= vid_nxt_s ? v_nxt_s[8:0] : 9'd0;
        col_r      <= vid_nxt_s ? h_nxt_s : 10'd0;
        video_on_r <= vid_nxt_s;
        hsync_r    <= hs_nxt_s;
        vsync_r    <= vs_nxt_s;
      end
    end
  end

  assign pix_tick    = pix_tick_r;
  assign row         = row_r;
  assign col         = col_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

`ifdef VGA_SCAN_PREFETCH_EN
  logic video_on_d_r, hsync_d_r, vsync_d_r;

  // One pixel of extra latency on sync/blank so consumers get a full pixel of pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      video_on_d_r <= 1'b0;
      hsync_d_r    <= 1'b1;
      vsync_d_r    <= 1'b1;
    end else if (advance_s) begin
      video_on_d_r <= video_on_r;
      hsync_d_r    <= hsync_r;
      vsync_d_r    <= vsync_r;
    end
  end

  assign video_on = video_on_d_r;
  assign hsync    = hsync_d_r;
  assign vsync    = vsync_d_r;
`else
  assign video_on = video_on_r;
  assign hsync    = hsync_r;
  assign vsync    = vsync_r;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: four configurations checked every clock against a pixel-index reference model.
module tb_vga_scan_gen;

  typedef struct packed {
    logic [8:0] row;
    logic [9:0] col;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       ls;
    logic       fs;
  } out_t;

`ifdef VGA_SCAN_PREFETCH_EN
  localparam bit PREF = 1'b1;
`else
  localparam bit PREF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       pt_a, vid_a, hs_a, vs_a, ls_a, fs_a;
  logic [8:0] row_a;
  logic [9:0] col_a;
  logic       pt_b, vid_b, hs_b, vs_b, ls_b, fs_b;
  logic [8:0] row_b;
  logic [9:0] col_b;
  logic       pt_c, vid_c, hs_c, vs_c, ls_c, fs_c;
  logic [8:0] row_c;
  logic [9:0] col_c;
  logic       pt_d, vid_d, hs_d, vs_d, ls_d, fs_d;
  logic [8:0] row_d;
  logic [9:0] col_d;

  vga_scan_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2),
                 .V_BP(2), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .pix_tick(pt_a), .row(row_a), .col(col_a), .video_on(vid_a),
    .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a));

  vga_scan_gen #(.H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(6), .V_FP(1), .V_SYNC(1),
                 .V_BP(2), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .pix_tick(pt_b), .row(row_b), .col(col_b), .video_on(vid_b),
    .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b));

  vga_scan_gen dut_c (
    .clk(clk), .reset(reset), .pix_tick(pt_c), .row(row_c), .col(col_c), .video_on(vid_c),
    .hsync(hs_c), .vsync(vs_c), .line_start(ls_c), .frame_start(fs_c));

  vga_scan_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2),
                 .V_BP(2), .CLK_DIV(3)) dut_d (
    .clk(clk), .reset(reset), .pix_tick(pt_d), .row(row_d), .col(col_d), .video_on(vid_d),
    .hsync(hs_d), .vsync(vs_d), .line_start(ls_d), .frame_start(fs_d));

  // {video_on, hsync, vsync} for the q-th pixel scanned since release (q=0: reset values).
  function automatic logic [2:0] sig_at(int q, int ha, int hfp, int hs, int hbp,
                                        int va, int vfp, int vs, int vbp);
    int ht, vt, l, h, v;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    if (q < 1) return 3'b011;
    l = (q - 1) % (ht * vt);
    h = l % ht;
    v = l / ht;
    return {(h < ha) && (v < va), !((h >= ha + hfp) && (h < ha + hfp + hs)),
            !((v >= va + vfp) && (v < va + vfp + vs))};
  endfunction

  // Expected outputs after the n-th clock edge with reset low (n=0: in or just out of reset).
  function automatic out_t model(int nn, int div, int ha, int hfp, int hs, int hbp,
                                 int va, int vfp, int vs, int vbp);
    out_t o;
    int ht, vt, p, l, h, v;
    logic [2:0] s;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    o = '0;
    p = nn / div;
    if (p >= 1) begin
      l = (p - 1) % (ht * vt);
      h = l % ht;
      v = l / ht;
      if ((h < ha) && (v < va)) begin
        o.col = 10'(h);
        o.row = 9'(v);
      end
      o.pt = ((nn % div) == 0);
      o.ls = o.pt && (h == 0);
      o.fs = o.pt && (l == 0);
    end
    s = sig_at(PREF ? p - 1 : p, ha, hfp, hs, hbp, va, vfp, vs, vbp);
    o.vid = s[2];
    o.hs  = s[1];
    o.vs  = s[0];
    return o;
  endfunction

  task automatic chk(input string tag, input out_t obs, input out_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h (row,col,vid,hs,vs,pt,ls,fs)", tag, n, obs, exp);
    end
  endtask

  task automatic cycle(input logic r);
    reset = r;
    @(posedge clk);
    #1;
    if (r) n = 0;
    else n++;
    chk("div2_small", {row_a, col_a, vid_a, hs_a, vs_a, pt_a, ls_a, fs_a},
        model(n, 2, 16, 2, 3, 3, 8, 1, 2, 2));
    chk("div1_small", {row_b, col_b, vid_b, hs_b, vs_b, pt_b, ls_b, fs_b},
        model(n, 1, 10, 1, 2, 1, 6, 1, 1, 2));
    chk("div2_default", {row_c, col_c, vid_c, hs_c, vs_c, pt_c, ls_c, fs_c},
        model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    chk("div3_small", {row_d, col_d, vid_d, hs_d, vs_d, pt_d, ls_d, fs_d},
        model(n, 3, 16, 2, 3, 3, 8, 1, 2, 2));
  endtask

  initial begin
    int run_len;
    int rst_len;
    // Reset for 3 clocks, then one long run covering two default lines and several small frames.
    for (int i = 0; i < 3; i++) cycle(1'b1);
    for (int i = 0; i < 3500; i++) cycle(1'b0);
    // Randomly timed mid-frame resets of random length.
    for (int k = 0; k < 10; k++) begin
      rst_len = int'($urandom_range(3, 1));
      for (int i = 0; i < rst_len; i++) cycle(1'b1);
      run_len = int'($urandom_range(900, 30));
      for (int i = 0; i < run_len; i++) cycle(1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

- Raster scan generator that produces the `row`/`col` pixel coordinates consumed by the sprite and animation lookup blocks.
- Also drives the VGA sync and blanking signals for the display.
- Runs counters for a configurable horizontal/vertical timing (default 640x480 @ 60 Hz). A clock divider sets the pixel rate from the system clock.
- All outputs are registered.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `CLK_DIV`, 2: system clocks per pixel (>=1)
- `clk`  in  1  system clock; one clock, all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `pix_tick`  out  1  one-clk strobe in the first clock of each pixel period
- `row`  out  9  active line index 0..V_ACTIVE-1; 0 outside active area
- `col`  out  10  active pixel index 0..H_ACTIVE-1; 0 outside active area
- `video_on`  out  1  high when the current position is inside the active area
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `line_start`  out  1  one-clk strobe when h position enters 0
- `frame_start`  out  1  one-clk strobe when position enters (0,0)

## Operation
- Internal counters:
  - `div_cnt` counts 0..CLK_DIV-1.
  - `h_cnt` counts 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). Width is 10 bits.
  - `v_cnt` counts 0..V_TOTAL-1, with V_TOTAL = 525. Width is 10 bits.
- Advance: the position advances on the edge where `div_cnt` == CLK_DIV-1. On that edge:
  - `div_cnt` wraps to 0.
  - `h_cnt` increments, wrapping H_TOTAL-1 -> 0.
  - On the h wrap, `v_cnt` increments, wrapping V_TOTAL-1 -> 0.
- Outputs are computed from the next-state position and registered on the same advance edge. They hold for the whole pixel period.
- Output decode:
  - `video_on` = h<H_ACTIVE && v<V_ACTIVE.
  - `col` = h when video_on, else 0.
  - `row` = v[8:0] when video_on, else 0.
  - `hsync` low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vsync` low for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
- Strobes: `pix_tick`, `line_start` and `frame_start` go high only on an advance edge and last exactly one clk.
  - `line_start` when the new h == 0.
  - `frame_start` when the new h == 0 and new v == 0. `line_start` is also high on that edge.
- Reset state is the last pixel of the frame: h=H_TOTAL-1, v=V_TOTAL-1, div_cnt=0.
- Reset values of outputs: `row`=0, `col`=0, `video_on`=0, `hsync`=1, `vsync`=1, `pix_tick`=0, `line_start`=0, `frame_start`=0.
- Reset asserted mid-frame: on the next edge all state and outputs take their reset values. No partial line or frame is completed.

## Timing
- First advance occurs CLK_DIV clocks after the first edge with `reset` low. On that edge the position enters (0,0):
  - `frame_start`, `line_start` and `pix_tick` are 1.
  - `video_on` is 1; `row` and `col` are 0.
- CLK_DIV=1: `pix_tick` is high every clock; no divider state.
- Periods:
  - Line period = H_TOTAL*CLK_DIV clocks (1600 default).
  - Frame period = H_TOTAL*V_TOTAL*CLK_DIV clocks (840000 default).
- Latency from counter to output is zero pixel periods: outputs describe the pixel currently being scanned.
- Consumers with one-clock ROM latency clocked on the opposite edge see data within the same pixel period when CLK_DIV>=2.

## Configuration
- `VGA_SCAN_PREFETCH_EN` defined:
  - `hsync`, `vsync` and `video_on` pass through one extra pixel-period register, updated on advance edges. They lag `row`/`col`/strobes by exactly one pixel period, giving consumers a full pixel of pipeline latency.
  - The extra register resets to `video_on`=0, `hsync`=1, `vsync`=1.
- Not defined: all outputs are aligned as described in Operation.

## Test plan
- Reset high 3 clocks, release, CLK_DIV=2 -> first `pix_tick`/`line_start`/`frame_start` on the 2nd clock after release, with `row`=0, `col`=0, `video_on`=1, `hsync`=1, `vsync`=1.
- Scan line 0 -> `col` counts 0..639 with `video_on`=1. At h=640, `video_on`=0 and `col`=0. `hsync` low for exactly 192 clocks, starting 656 pixels (1312 clks) after `line_start`.
- Run 2 frames -> `frame_start` spacing 840000 clocks; `line_start` spacing 1600 clocks. `vsync` low for 3200 clocks starting at line 490. Max `row` observed is 479.
- Assert reset 1 clock at h=300, v=200 -> outputs take reset values on the next edge. `frame_start` fires CLK_DIV clocks after release, at `row`=0, `col`=0.
- CLK_DIV=1 -> `pix_tick` constantly 1; `frame_start` spacing 420000 clocks.
- `VGA_SCAN_PREFETCH_EN` defined, CLK_DIV=2 -> `video_on` rises 2 clocks after `frame_start`. At h=640 `col` goes to 0 while `video_on` stays 1 for 2 more clocks.
